// File: rtl/hazard_scoreboard_pkg.sv
// Shared definitions for the decode-stage hazard scoreboard.
//   - tnew/tuse encoding constants (cycles until produced / consumed)
//   - default multiply/divide occupancy lengths
//   - post-decode stage indices as used by the forwarding selects
//   - sel_w(): width of a forwarding select able to name stages 0..DEPTH
package hazard_scoreboard_pkg;

    localparam int TNEW_W_DEF      = 2;
    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // tnew/tuse values: number of cycles before the value is ready / needed
    localparam logic [TNEW_W_DEF-1:0] T_NOW   = 2'd0;
    localparam logic [TNEW_W_DEF-1:0] T_ONE   = 2'd1;
    localparam logic [TNEW_W_DEF-1:0] T_TWO   = 2'd2;
    localparam logic [TNEW_W_DEF-1:0] T_THREE = 2'd3;

    // Forwarding select values; 0 means "take the register file"
    localparam int STG_RF = 0;
    localparam int STG_E  = 1;
    localparam int STG_M  = 2;
    localparam int STG_W  = 3;

    function automatic int sel_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/hazard_operand_check.sv
// Per-operand hazard check against the scoreboard entries.
// Finds the youngest in-flight writer of src (older writers are shadowed),
// then reports whether it is too late for this operand (stall_bit) and,
// if its value is already forwardable, which stage to forward from (sel).
// Ports:
//   ent_valid/ent_dst/ent_tnew  scoreboard entries, index 0 = stage 1 (E)
//   src, src_use, tuse          operand address, read flag, cycles until use
//   stall_bit                   youngest writer's tnew exceeds tuse
//   sel                         stage number of forwardable youngest writer, else 0
module hazard_operand_check
    import hazard_scoreboard_pkg::*;
#(
    parameter int DEPTH  = 3,
    parameter int TNEW_W = 2,
    parameter int SEL_W  = 2
) (
    input  logic [DEPTH-1:0]             ent_valid,
    input  logic [DEPTH-1:0][4:0]        ent_dst,
    input  logic [DEPTH-1:0][TNEW_W-1:0] ent_tnew,
    input  logic [4:0]                   src,
    input  logic                         src_use,
    input  logic [TNEW_W-1:0]            tuse,
    output logic                         stall_bit,
    output logic [SEL_W-1:0]             sel
);

    logic              hit;
    logic [TNEW_W-1:0] hit_tnew;
    logic [SEL_W-1:0]  hit_stage;

    always_comb begin
        hit       = 1'b0;
        hit_tnew  = '0;
        hit_stage = '0;
        // Walk oldest to youngest so the youngest match is the last one written
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (ent_valid[k] && (ent_dst[k] == src) && (src != 5'd0) && src_use) begin
                hit       = 1'b1;
                hit_tnew  = ent_tnew[k];
                hit_stage = SEL_W'(k + 1);
            end
        end
        stall_bit = hit && (hit_tnew > tuse);
        sel       = (hit && (hit_tnew == '0)) ? hit_stage : '0;
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard for the pipelined MIPS core.
// Mirrors DEPTH post-decode pipeline stages as {valid, dst, tnew} entries,
// shifted in lockstep with the pipeline registers, and models the
// multiply/divide unit occupancy.
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   d_rs/d_rt, *_use, *_tuse    D-stage operand addresses, read flags, cycles until use
//   d_dst, d_dst_valid, d_tnew  D-stage destination and its result latency
//   d_is_md, d_md_start,
//   d_md_is_div                 D-stage HI/LO access, mult/div start, div qualifier
//   flush                       squash everything past D on this edge
//   stall                       freeze F/D and bubble E (combinational)
//   fwd_rs_sel/fwd_rt_sel       0 = register file, k = forward from stage k
//   md_busy                     multiply/divide unit occupied
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter  int DEPTH       = 3,
    parameter  int TNEW_W      = TNEW_W_DEF,
    parameter  int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter  int DIV_CYCLES  = DIV_CYCLES_DEF,
    localparam int SEL_W       = sel_w(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        d_rs,
    input  logic [4:0]        d_rt,
    input  logic              d_rs_use,
    input  logic              d_rt_use,
    input  logic [TNEW_W-1:0] d_rs_tuse,
    input  logic [TNEW_W-1:0] d_rt_tuse,
    input  logic [4:0]        d_dst,
    input  logic              d_dst_valid,
    input  logic [TNEW_W-1:0] d_tnew,
    input  logic              d_is_md,
    input  logic              d_md_start,
    input  logic              d_md_is_div,
    input  logic              flush,
    output logic              stall,
    output logic [SEL_W-1:0]  fwd_rs_sel,
    output logic [SEL_W-1:0]  fwd_rt_sel,
    output logic              md_busy
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    function automatic logic [TNEW_W-1:0] tnew_sat_dec(input logic [TNEW_W-1:0] t);
        return (t == '0) ? '0 : t - TNEW_W'(1);
    endfunction

    logic [DEPTH-1:0]             vld_q, vld_d;
    logic [DEPTH-1:0][4:0]        dst_q, dst_d;
    logic [DEPTH-1:0][TNEW_W-1:0] tnew_q, tnew_d;
    logic                         md_in_e_q, md_in_e_d;
    logic                         md_is_div_q, md_is_div_d;
    logic [CNT_W-1:0]             md_cnt_q, md_cnt_d;

    logic             rs_stall, rt_stall, md_stall, issue, load_e;
    logic [SEL_W-1:0] rs_sel, rt_sel;

    hazard_operand_check #(.DEPTH(DEPTH), .TNEW_W(TNEW_W), .SEL_W(SEL_W)) u_rs_check (
        .ent_valid (vld_q),
        .ent_dst   (dst_q),
        .ent_tnew  (tnew_q),
        .src       (d_rs),
        .src_use   (d_rs_use),
        .tuse      (d_rs_tuse),
        .stall_bit (rs_stall),
        .sel       (rs_sel)
    );

    hazard_operand_check #(.DEPTH(DEPTH), .TNEW_W(TNEW_W), .SEL_W(SEL_W)) u_rt_check (
        .ent_valid (vld_q),
        .ent_dst   (dst_q),
        .ent_tnew  (tnew_q),
        .src       (d_rt),
        .src_use   (d_rt_use),
        .tuse      (d_rt_tuse),
        .stall_bit (rt_stall),
        .sel       (rt_sel)
    );

    assign md_busy    = (md_cnt_q != '0) | md_in_e_q;
    assign md_stall   = d_is_md & md_busy;
    assign stall      = rs_stall | rt_stall | md_stall;
    assign issue      = ~stall;
    // A stalled D slot never forwards: the operand is re-evaluated next cycle
    assign fwd_rs_sel = stall ? '0 : rs_sel;
    assign fwd_rt_sel = stall ? '0 : rt_sel;

    // Scoreboard shift: D -> E (entry index 0) -> ... -> retire
    always_comb begin
        load_e    = issue & d_dst_valid & (d_dst != 5'd0) & ~flush;
        vld_d     = '0;
        dst_d     = '0;
        tnew_d    = '0;
        vld_d[0]  = load_e;
        dst_d[0]  = load_e ? d_dst  : 5'd0;
        tnew_d[0] = load_e ? d_tnew : '0;
        for (int k = 1; k < DEPTH; k++) begin
            vld_d[k]  = vld_q[k-1] & ~flush;
            dst_d[k]  = dst_q[k-1];
            tnew_d[k] = tnew_sat_dec(tnew_q[k-1]);
        end
    end

    // Multiply/divide occupancy: one cycle in E, then the loaded countdown.
    // A flushed op in E never starts the unit; an already running count finishes.
    always_comb begin
        md_in_e_d   = issue & d_md_start & ~flush;
        md_is_div_d = (issue & d_md_start) ? d_md_is_div : md_is_div_q;
        if (md_in_e_q && !flush) begin
            md_cnt_d = md_is_div_q ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - CNT_W'(1);
        end else begin
            md_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q       <= '0;
            dst_q       <= '0;
            tnew_q      <= '0;
            md_in_e_q   <= 1'b0;
            md_is_div_q <= 1'b0;
            md_cnt_q    <= '0;
        end else begin
            vld_q       <= vld_d;
            dst_q       <= dst_d;
            tnew_q      <= tnew_d;
            md_in_e_q   <= md_in_e_d;
            md_is_div_q <= md_is_div_d;
            md_cnt_q    <= md_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

    logic       clk;
    logic       reset;
    logic [4:0] d_rs, d_rt, d_dst;
    logic       d_rs_use, d_rt_use, d_dst_valid;
    logic [1:0] d_rs_tuse, d_rt_tuse, d_tnew;
    logic       d_is_md, d_md_start, d_md_is_div, flush;

    logic       stall, md_busy;
    logic [1:0] fwd_rs_sel, fwd_rt_sel;
    logic       stall4, md_busy4;
    logic [2:0] fwd_rs_sel4, fwd_rt_sel4;

    int n_cmp = 0;
    int n_bad = 0;
    int stall_cycles;

    hazard_scoreboard #(.DEPTH(3), .TNEW_W(2), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset),
        .d_rs(d_rs), .d_rt(d_rt), .d_rs_use(d_rs_use), .d_rt_use(d_rt_use),
        .d_rs_tuse(d_rs_tuse), .d_rt_tuse(d_rt_tuse),
        .d_dst(d_dst), .d_dst_valid(d_dst_valid), .d_tnew(d_tnew),
        .d_is_md(d_is_md), .d_md_start(d_md_start), .d_md_is_div(d_md_is_div),
        .flush(flush),
        .stall(stall), .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel), .md_busy(md_busy)
    );

    hazard_scoreboard #(.DEPTH(4), .TNEW_W(2), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut4 (
        .clk(clk), .reset(reset),
        .d_rs(d_rs), .d_rt(d_rt), .d_rs_use(d_rs_use), .d_rt_use(d_rt_use),
        .d_rs_tuse(d_rs_tuse), .d_rt_tuse(d_rt_tuse),
        .d_dst(d_dst), .d_dst_valid(d_dst_valid), .d_tnew(d_tnew),
        .d_is_md(d_is_md), .d_md_start(d_md_start), .d_md_is_div(d_md_is_div),
        .flush(flush),
        .stall(stall4), .fwd_rs_sel(fwd_rs_sel4), .fwd_rt_sel(fwd_rt_sel4), .md_busy(md_busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change and checks happen 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic d_nop();
        d_rs = 0; d_rt = 0; d_rs_use = 0; d_rt_use = 0; d_rs_tuse = 0; d_rt_tuse = 0;
        d_dst = 0; d_dst_valid = 0; d_tnew = 0;
        d_is_md = 0; d_md_start = 0; d_md_is_div = 0; flush = 0;
    endtask

    task automatic d_write(input logic [4:0] dst, input logic [1:0] tnew);
        d_nop();
        d_dst = dst; d_dst_valid = 1; d_tnew = tnew;
    endtask

    task automatic d_read_rs(input logic [4:0] rs, input logic [1:0] tuse);
        d_nop();
        d_rs = rs; d_rs_use = 1; d_rs_tuse = tuse;
    endtask

    task automatic drain();
        d_nop();
        repeat (4) step();
    endtask

    task automatic md_start(input logic is_div);
        d_nop();
        d_is_md = 1; d_md_start = 1; d_md_is_div = is_div;
    endtask

    // Hold mflo in D and count how many cycles it is held back
    task automatic count_md_stall(output int cycles);
        d_nop();
        d_is_md = 1;
        cycles = 0;
        #1;
        for (int i = 0; i < 30; i++) begin
            if (!stall) break;
            cycles++;
            step();
        end
    endtask

    initial begin
        d_nop();
        reset = 1;
        #1;
        check("reset_stall", stall, 0);
        check("reset_rs_sel", fwd_rs_sel, 0);
        check("reset_md_busy", md_busy, 0);
        step();
        reset = 0;

        // lw $8 (tnew=2) then addu reading $8 at tuse=1
        d_write(8, 2);
        step();
        d_read_rs(8, 1); d_dst = 9; d_dst_valid = 1; d_tnew = 1;
        #1;
        check("lw_use_stall", stall, 1);
        check("lw_use_sel_stalled", fwd_rs_sel, 0);
        step();
        check("lw_use_release", stall, 0);
        check("lw_use_sel_pending", fwd_rs_sel, 0);
        step();
        d_read_rs(8, 1);
        #1;
        check("lw_later_sel_w", fwd_rs_sel, 3);
        check("lw_later_sel_w_d4", fwd_rs_sel4, 3);
        d_nop();
        step();
        d_read_rs(8, 0);
        #1;
        check("retired_sel_d3", fwd_rs_sel, 0);
        check("stage4_sel_d4", fwd_rs_sel4, 4);
        check("stage4_stall", stall4, 0);

        // addu $8 (tnew=1) then beq reading $8 on both operands at tuse=0
        drain();
        d_write(8, 1);
        step();
        d_read_rs(8, 0); d_rt = 8; d_rt_use = 1; d_rt_tuse = 0;
        #1;
        check("beq_stall", stall, 1);
        step();
        check("beq_release", stall, 0);
        check("beq_rs_sel_m", fwd_rs_sel, 2);
        check("beq_rt_sel_m", fwd_rt_sel, 2);

        // two writers of $8: younger (E, tnew=1) shadows older (M, tnew=0)
        drain();
        d_write(8, 1);
        step();
        d_write(8, 1);
        step();
        d_read_rs(8, 1);
        #1;
        check("shadow_stall", stall, 0);
        check("shadow_sel", fwd_rs_sel, 0);
        step();
        check("shadow_next_sel", fwd_rs_sel, 2);

        // $0 is never a hazard
        drain();
        d_write(0, 2);
        step();
        d_read_rs(0, 0);
        #1;
        check("r0_stall", stall, 0);
        check("r0_sel", fwd_rs_sel, 0);

        // flush squashes lw $8 in E
        drain();
        d_write(8, 2);
        step();
        d_nop(); flush = 1;
        step();
        d_read_rs(8, 0);
        #1;
        check("flush_stall", stall, 0);
        check("flush_sel", fwd_rs_sel, 0);

        // div then mflo: 1 cycle in E + 10 counter cycles
        drain();
        md_start(1);
        #1;
        check("div_issue_stall", stall, 0);
        step();
        check("div_md_busy", md_busy, 1);
        count_md_stall(stall_cycles);
        check("div_stall_cycles", stall_cycles, 11);
        check("div_busy_done", md_busy, 0);

        // mult then mflo: 1 + 5
        drain();
        md_start(0);
        step();
        count_md_stall(stall_cycles);
        check("mult_stall_cycles", stall_cycles, 6);
        check("mult_busy_done", md_busy, 0);

        // asynchronous reset mid-div (counter at 6) with lw $8 in flight
        drain();
        md_start(1);
        step();
        d_nop();
        repeat (4) step();
        d_write(8, 2);
        step();
        d_read_rs(8, 0);
        #1;
        check("pre_reset_busy", md_busy, 1);
        check("pre_reset_stall", stall, 1);
        reset = 1;
        #1;
        check("async_reset_busy", md_busy, 0);
        check("async_reset_stall", stall, 0);
        check("async_reset_sel", fwd_rs_sel, 0);
        #1;
        reset = 0;
        step();
        check("post_reset_busy", md_busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
